mo_operand_server: RTL
======================

Name: mo_operand_server

Overview:
- RTL operand/result server that sits directly upstream and downstream of the MO matrix engine.
- Holds the operand image (n, r, A, X, B) in an internal 10-bit array and answers MO's opcode/i/j requests combinationally on in_data.
- Captures MO's WRITE_Y stream into a 20-bit result array and controls MO's reset.
- A host loads operands, pulses start, waits for done, then reads Y back.

Parameters:
- DEPTH, 1024, operand array entries; address 0 = n, address 1 = r.
- YDEPTH, 1024, result array entries.
- TIMEOUT, 1000000, max RUN cycles before forced DONE with err.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  host start pulse.
- ld_we  in  1  host operand write enable.
- ld_addr  in  10  host operand write address.
- ld_data  in  10  host operand write data.
- rd_addr  in  10  host result read address.
- rd_data  out  20  result array read data, combinational.
- busy  out  1  high in PRIME or RUN.
- done  out  1  high in DONE.
- err  out  1  sticky error flag.
- mo_rst_n  out  1  registered active-low reset to MO.
- opcode  in  3  MO opcode.
- i  in  10  MO row index.
- j  in  10  MO column index.
- out_data  in  20  MO Y element.
- fin  in  1  MO completion.
- in_data  out  10  operand data to MO.

Behaviour:
- FSM states:
  - IDLE: reset state; host owns the operand array.
  - PRIME: exactly 1 cycle.
  - RUN
  - DONE
- Async reset (reset=0), immediate: state=IDLE, mo_rst_n=0, busy=0, done=0, err=0, y_cnt=0, timer=0. Operand and result arrays are not cleared.
- IDLE: ld_we=1 writes ld_data to op[ld_addr] on the clock edge. ld_we is ignored in every other state.
- start=1 in IDLE or DONE moves to PRIME. In PRIME: latch nn=n*n, nr=n*r (20-bit, from op[0], op[1]); clear y_cnt, err, timer; mo_rst_n stays 0. start is ignored in PRIME and RUN.
- PRIME -> RUN. mo_rst_n is registered high from the first RUN cycle; it is 0 in every other state.
- RUN, in_data is combinational from opcode/i/j. All address arithmetic is 20-bit unsigned.
  - GET_N(000): addr 0.
  - GET_R(001): addr 1.
  - READ_A(010): i*r+j+2.
  - READ_X(011): i*n+j+2+nr.
  - READ_B(100): i*n+j+2+2*nr.
  - WRITE_Y(101) and 110/111: in_data=0.
  - addr>=DEPTH: in_data=0 and err is set at the next edge.
- in_data=0 outside RUN.
- WRITE_Y in RUN, each cycle: if y_cnt<nn and y_cnt<YDEPTH, y[y_cnt]<=out_data and y_cnt++. Otherwise the write is dropped and err=1. Consecutive WRITE_Y cycles are each a separate write.
- fin=1 in RUN -> DONE next edge. err is set if y_cnt (after including any same-cycle write) != nn.
- A WRITE_Y in the same cycle as fin is still captured.
- timer increments every RUN cycle. timer==TIMEOUT-1 -> DONE with err=1.
- DONE: done=1, MO held in reset, fin ignored, results stable.
- rd_data = y[rd_addr], valid in all states.
- Host writes in IDLE take effect for the next start. Writes attempted during RUN are dropped and do not set err.
- n=0: nn=0, any WRITE_Y sets err, fin ends cleanly with err=0.

Test Plan:
- Reset: assert reset mid-cycle -> busy=0, done=0, err=0, mo_rst_n=0, in_data=0 immediately, without waiting for a clock edge.
- Address map: load op[0]=2, op[1]=3, op[7]=11, op[13]=22, op[17]=33; start; in RUN drive:
  - GET_N -> in_data=2.
  - GET_R -> in_data=3.
  - READ_A i=1,j=2 -> in_data=11.
  - READ_X i=2,j=1 -> in_data=22.
  - READ_B i=1,j=1 -> in_data=33.
  - err=0 throughout.
- Result capture: n=2, r=2; WRITE_Y with out_data 20,23,44,51 on 4 consecutive cycles, then fin -> done=1, err=0, rd_addr 0..3 returns 20,23,44,51. mo_rst_n=0 exactly 1 cycle in PRIME and high through RUN.
- Count errors:
  - Case 1: n=2, 5 WRITE_Y with values 1..5 -> y[0..3]=1..4, fifth write dropped, err=1.
  - Case 2: rerun via start from DONE with 3 writes then fin -> err=1.
- Out of range: n=r=20, READ_B i=31,j=0 (addr 1422) -> in_data=0, err=1. Set TIMEOUT=50 with no fin -> DONE at cycle 50 with err=1.
- Reset mid-RUN after 2 writes -> IDLE, y_cnt=0, operands retained. Start again -> GET_N returns the old n.

Source files
------------

// File: rtl/mo_operand_server.sv
// mo_operand_server: operand image and result store around the MO engine.
// Serves MO operand reads, captures WRITE_Y results, sequences MO reset.
module mo_operand_server #(
  parameter int DEPTH   = 1024,
  parameter int YDEPTH  = 1024,
  parameter int TIMEOUT = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        ld_we,
  input  logic [9:0]  ld_addr,
  input  logic [9:0]  ld_data,
  input  logic [9:0]  rd_addr,
  output logic [19:0] rd_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        mo_rst_n,
  input  logic [2:0]  opcode,
  input  logic [9:0]  i,
  input  logic [9:0]  j,
  input  logic [19:0] out_data,
  input  logic        fin,
  output logic [9:0]  in_data
);

  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int YAW = (YDEPTH > 1) ? $clog2(YDEPTH) : 1;
  localparam logic [19:0] D20   = 20'(DEPTH);
  localparam logic [19:0] Y20   = 20'(YDEPTH);
  localparam logic [31:0] TO_M1 = 32'(TIMEOUT - 1);

  localparam logic [2:0] OP_GET_N  = 3'b000;
  localparam logic [2:0] OP_GET_R  = 3'b001;
  localparam logic [2:0] OP_READ_A = 3'b010;
  localparam logic [2:0] OP_READ_X = 3'b011;
  localparam logic [2:0] OP_READ_B = 3'b100;
  localparam logic [2:0] OP_WR_Y   = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRIME,
    S_RUN,
    S_DONE
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [9:0]  r_op [DEPTH];
  logic [19:0] r_y  [YDEPTH];
  logic [19:0] r_nn;
  logic [19:0] r_nr;
  logic [19:0] r_ycnt;
  logic [31:0] r_timer;
  logic        r_err;
  logic        r_mo_rst_n;

  logic        w_run;
  logic        w_rd;
  logic [19:0] w_addr;
  logic        w_oob;
  logic [19:0] w_i;
  logic [19:0] w_j;
  logic [19:0] w_n;
  logic [19:0] w_r;
  logic        w_wy;
  logic        w_wok;
  logic [19:0] w_cnt;
  logic        w_to;
  logic        w_fin;
  logic        w_err_set;
  logic [19:0] w_ldx;
  logic [19:0] w_rdx;

  assign w_run = (r_state == S_RUN);
  assign w_i   = {10'd0, i};
  assign w_j   = {10'd0, j};
  assign w_n   = {10'd0, r_op[0]};
  assign w_r   = {10'd0, r_op[1]};
  assign w_ldx = {10'd0, ld_addr};
  assign w_rdx = {10'd0, rd_addr};

  // Map an MO request onto an operand-array address
  always_comb begin
    w_rd   = 1'b0;
    w_addr = '0;
    case (opcode)
      OP_GET_N: w_rd = 1'b1;
      OP_GET_R: begin
        w_rd   = 1'b1;
        w_addr = 20'd1;
      end
      OP_READ_A: begin
        w_rd   = 1'b1;
        w_addr = w_i * w_r + w_j + 20'd2;
      end
      OP_READ_X: begin
        w_rd   = 1'b1;
        w_addr = w_i * w_n + w_j + 20'd2 + r_nr;
      end
      OP_READ_B: begin
        w_rd   = 1'b1;
        w_addr = w_i * w_n + w_j + 20'd2
               + (r_nr << 1);
      end
      default: w_rd = 1'b0;
    endcase
  end

  assign w_oob   = w_run & w_rd & (w_addr >= D20);
  assign in_data = (w_run & w_rd & ~w_oob)
                 ? r_op[w_addr[AW-1:0]] : '0;

  assign w_wy  = w_run && (opcode == OP_WR_Y);
  assign w_wok = w_wy && (r_ycnt < r_nn)
              && (r_ycnt < Y20);
  assign w_cnt = r_ycnt + {19'd0, w_wok};
  assign w_to  = w_run && (r_timer == TO_M1);
  assign w_fin = w_run && fin;

  assign w_err_set = w_oob
                   | (w_wy & ~w_wok)
                   | (w_fin & (w_cnt != r_nn))
                   | w_to;

  // Next-state: PRIME lasts one cycle, RUN ends on fin or timeout
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_PRIME;
      S_PRIME: w_next = S_RUN;
      S_RUN:   if (fin || w_to) w_next = S_DONE;
      S_DONE:  if (start) w_next = S_PRIME;
      default: w_next = S_IDLE;
    endcase
  end

  // Control state, counters and sticky error
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_mo_rst_n <= 1'b0;
      r_err      <= 1'b0;
      r_ycnt     <= '0;
      r_timer    <= '0;
      r_nn       <= '0;
      r_nr       <= '0;
    end else begin
      r_state    <= w_next;
      r_mo_rst_n <= (w_next == S_RUN);
      if (r_state == S_PRIME) begin
        r_nn    <= w_n * w_n;
        r_nr    <= w_n * w_r;
        r_ycnt  <= '0;
        r_err   <= 1'b0;
        r_timer <= '0;
      end else if (w_run) begin
        r_timer <= r_timer + 32'd1;
        r_ycnt  <= w_cnt;
        if (w_err_set) r_err <= 1'b1;
      end
    end
  end

  // Host operand loads, accepted only while idle; kept across reset
  always_ff @(posedge clk) begin
    if ((r_state == S_IDLE) && ld_we && (w_ldx < D20))
      r_op[w_ldx[AW-1:0]] <= ld_data;
  end

  // Result capture from the MO WRITE_Y stream; kept across reset
  always_ff @(posedge clk) begin
    if (w_wok) r_y[r_ycnt[YAW-1:0]] <= out_data;
  end

  assign rd_data  = (w_rdx < Y20) ? r_y[w_rdx[YAW-1:0]] : '0;
  assign busy     = (r_state == S_PRIME) || w_run;
  assign done     = (r_state == S_DONE);
  assign err      = r_err;
  assign mo_rst_n = r_mo_rst_n;

endmodule
